// File: rtl/comb_inverse_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// comb_inverse_filter: y = (x - 0.875*x[n-DEPTH]) <<< OUT_SHIFT, removes a comb echo.
// Define COMB_INV_SAT_EN to saturate the result, otherwise it wraps. Rev 1.0
// -----------------------------------------------------------------------------
module comb_inverse_filter #(
  parameter int DEPTH     = 2048,
  parameter int OUT_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [31:0] in,
  output logic               out_valid,
  output logic signed [31:0] out,
  output logic               primed
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = 35 + OUT_SHIFT;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  typedef enum logic [1:0] {M_BYPASS = 2'd0, M_FILL = 2'd1, M_RUN = 2'd2} mode_t;

  state_t             state;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      fill_cnt;
  logic               s1_valid;
  mode_t              s1_mode;
  logic signed [31:0] s1_in;
  logic signed [31:0] s1_d;
  logic signed [31:0] ram [DEPTH];
  logic               ram_we;

  assign ram_we = enable && in_valid;

  // Read-first delay line: the old sample at wr_ptr is captured as it is overwritten.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      s1_d        <= ram[wr_ptr];
      ram[wr_ptr] <= in;
    end
  end

  logic signed [31:0]   d_eff;
  logic signed [34:0]   in_x;
  logic signed [34:0]   d_x;
  logic signed [34:0]   diff;
  logic signed [SW-1:0] sh;
  logic signed [31:0]   result;

  always_comb begin
    d_eff = (s1_mode == M_RUN) ? s1_d : 32'sd0;
    in_x  = {{3{s1_in[31]}}, s1_in};
    d_x   = {{3{d_eff[31]}}, d_eff};
    diff  = in_x - (d_x >>> 1) - (d_x >>> 2) - (d_x >>> 3);
    sh    = SW'(diff) <<< OUT_SHIFT;
`ifdef COMB_INV_SAT_EN
    if ((sh[SW-1:31] == {(SW-31){1'b0}}) || (sh[SW-1:31] == {(SW-31){1'b1}}))
      result = sh[31:0];
    else
      result = sh[SW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    result = 32'(sh);
`endif
    if (s1_mode == M_BYPASS)
      result = s1_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      primed    <= 1'b0;
      s1_valid  <= 1'b0;
      s1_mode   <= M_BYPASS;
      s1_in     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid)
        s1_in <= in;
      if (s1_valid)
        out <= result;

      if (!enable) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        fill_cnt <= '0;
        primed   <= 1'b0;
        if (in_valid)
          s1_mode <= M_BYPASS;
      end else if (in_valid) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (state == RUN) begin
          s1_mode <= M_RUN;
        end else begin
          // The first enabled sample out of IDLE is already a fill sample.
          s1_mode  <= M_FILL;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == LAST_CNT) begin
            state  <= RUN;
            primed <= 1'b1;
          end else begin
            state <= FILL;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
